// File: rtl/sigmoid_pkg.sv
// Shared constants and types for the PLAN logistic sampler: breakpoints, intercepts,
// LFSR tap mask and the per-beat mode / segment enums.
package sigmoid_pkg;

    localparam real BP_SAT = 5.0;
    localparam real BP_MID = 2.375;
    localparam real BP_LO  = 1.0;

    localparam real IC_HI  = 0.84375;
    localparam real IC_MID = 0.625;
    localparam real IC_LO  = 0.5;

    // Galois form of x^16 + x^14 + x^13 + x^11, shifting right.
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef enum logic { PROB = 1'b0, SAMPLE = 1'b1 } mode_e;

    typedef enum logic [1:0] { SEG_SAT, SEG_HI, SEG_MID, SEG_LO } seg_e;

    function automatic int to_fixed(input real v, input int frac);
        return $rtoi(v * real'(2 ** frac));
    endfunction

    function automatic int pos_part(input int n);
        return (n > 0) ? n : 0;
    endfunction

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
    endfunction

endpackage

// File: rtl/plan_lane.sv
// One lane of the sampler: abs/compare, segment evaluation, sign fold and Bernoulli draw,
// with per-stage load enables supplied by the shared handshake logic.
module plan_lane
    import sigmoid_pkg::*;
#(
    parameter int          SUM_W     = 16,
    parameter int          FRAC_BITS = 4,
    parameter int          OUT_W     = 8,
    parameter logic [15:0] SEED      = 16'hACE1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_ld1,
    input  logic             i_ld2,
    input  logic             i_ld3,
    input  logic             i_sample,
    input  logic [SUM_W-1:0] i_sum,
    output logic [OUT_W-1:0] o_prob,
    output logic             o_state
);

    localparam int ABS_W = SUM_W + 1;
    localparam int EXT_W = ABS_W + OUT_W;
    localparam int Y_W   = OUT_W + 1;

    localparam logic [ABS_W-1:0] TH_SAT = ABS_W'(to_fixed(BP_SAT, FRAC_BITS));
    localparam logic [ABS_W-1:0] TH_MID = ABS_W'(to_fixed(BP_MID, FRAC_BITS));
    localparam logic [ABS_W-1:0] TH_LO  = ABS_W'(to_fixed(BP_LO,  FRAC_BITS));

    localparam logic [Y_W-1:0] C_HI  = Y_W'(to_fixed(IC_HI,  OUT_W));
    localparam logic [Y_W-1:0] C_MID = Y_W'(to_fixed(IC_MID, OUT_W));
    localparam logic [Y_W-1:0] C_LO  = Y_W'(to_fixed(IC_LO,  OUT_W));
    localparam logic [Y_W-1:0] Y_ONE = {1'b1, {OUT_W{1'b0}}};

    // Rescale |x| from 2^-FRAC_BITS units to 2^-OUT_W units while dividing by 32, 8 or 4.
    localparam int N_HI  = OUT_W - FRAC_BITS - 5;
    localparam int N_MID = OUT_W - FRAC_BITS - 3;
    localparam int N_LO  = OUT_W - FRAC_BITS - 2;

    // ---------------- S1: sign, magnitude, segment ----------------
    logic             w_neg;
    logic [ABS_W-1:0] w_sx;
    logic [ABS_W-1:0] w_abs;
    seg_e             w_seg;

    assign w_neg = i_sum[SUM_W-1];
    assign w_sx  = {i_sum[SUM_W-1], i_sum};
    assign w_abs = w_neg ? -w_sx : w_sx;

    always_comb begin
        w_seg = SEG_LO;
        if (w_abs > TH_SAT)      w_seg = SEG_SAT;
        else if (w_abs > TH_MID) w_seg = SEG_HI;
        else if (w_abs > TH_LO)  w_seg = SEG_MID;
    end

    logic             r_s1_neg;
    logic [ABS_W-1:0] r_s1_abs;
    seg_e             r_s1_seg;

    // NOTE: datapath registers carry no reset; the valid chain in the top decides
    // whether their contents mean anything, so only the visible outputs are cleared.
    always_ff @(posedge clk) begin
        if (i_ld1) begin
            r_s1_neg <= w_neg;
            r_s1_abs <= w_abs;
            r_s1_seg <= w_seg;
        end
    end

    // ---------------- S2: piecewise-linear magnitude ----------------
    logic [EXT_W-1:0] w_abs_ext;
    logic [Y_W-1:0]   w_t_hi;
    logic [Y_W-1:0]   w_t_mid;
    logic [Y_W-1:0]   w_t_lo;
    logic [Y_W-1:0]   w_y;

    assign w_abs_ext = {{OUT_W{1'b0}}, r_s1_abs};
    assign w_t_hi    = Y_W'((w_abs_ext << pos_part(N_HI))  >> pos_part(-N_HI));
    assign w_t_mid   = Y_W'((w_abs_ext << pos_part(N_MID)) >> pos_part(-N_MID));
    assign w_t_lo    = Y_W'((w_abs_ext << pos_part(N_LO))  >> pos_part(-N_LO));

    always_comb begin
        w_y = C_LO + w_t_lo;
        case (r_s1_seg)
            SEG_SAT: w_y = Y_ONE;
            SEG_HI:  w_y = C_HI + w_t_hi;
            SEG_MID: w_y = C_MID + w_t_mid;
            default: w_y = C_LO + w_t_lo;
        endcase
    end

    logic           r_s2_neg;
    logic [Y_W-1:0] r_s2_y;

    always_ff @(posedge clk) begin
        if (i_ld2) begin
            r_s2_neg <= r_s1_neg;
            r_s2_y   <= w_y;
        end
    end

    // ---------------- S3: sign fold, saturate, Bernoulli draw ----------------
    logic [Y_W-1:0]   w_y3;
    logic [OUT_W-1:0] w_prob;
    logic             w_state;
    logic [OUT_W-1:0] r_prob;
    logic             r_state;
    logic [15:0]      r_lfsr;

    assign w_y3    = r_s2_neg ? (Y_ONE - r_s2_y) : r_s2_y;
    assign w_prob  = w_y3[OUT_W] ? {OUT_W{1'b1}} : w_y3[OUT_W-1:0];
    assign w_state = i_sample && (r_lfsr[15 -: OUT_W] < w_prob);

    // The draw uses the LFSR value held before this beat's step.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_prob  <= '0;
            r_state <= 1'b0;
            r_lfsr  <= SEED;
        end else if (i_ld3) begin
            r_prob  <= w_prob;
            r_state <= w_state;
            if (i_sample) r_lfsr <= lfsr_next(r_lfsr);
        end
    end

    assign o_prob  = r_prob;
    assign o_state = r_state;

endmodule

// File: rtl/sigmoid_sampler.sv
// Multi-lane pipelined PLAN sigmoid with optional Bernoulli sampling. Holds the shared
// three-stage valid/stall chain and one plan_lane per lane.
module sigmoid_sampler
    import sigmoid_pkg::*;
#(
    parameter int          NUM_LANES = 4,
    parameter int          SUM_W     = 16,
    parameter int          FRAC_BITS = 4,
    parameter int          OUT_W     = 8,
    parameter logic [15:0] SEED      = 16'hACE1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [NUM_LANES*SUM_W-1:0] in_sum,
    input  logic                       in_mode,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [NUM_LANES*OUT_W-1:0] out_prob,
    output logic [NUM_LANES-1:0]       out_state
);

    logic  r_s1_valid, r_s2_valid, r_s3_valid;
    mode_e r_s1_mode, r_s2_mode;

    logic w_en1, w_en2, w_en3;
    logic w_ld1, w_ld2, w_ld3;
    logic w_sample3;

    // NOTE: each stage may load when empty or when its contents move on this edge, so
    // the ready path is combinational back to out_ready and bubbles collapse.
    assign w_en3 = !r_s3_valid || out_ready;
    assign w_en2 = !r_s2_valid || w_en3;
    assign w_en1 = !r_s1_valid || w_en2;

    assign w_ld1     = in_valid && w_en1;
    assign w_ld2     = r_s1_valid && w_en2;
    assign w_ld3     = r_s2_valid && w_en3;
    assign w_sample3 = (r_s2_mode == SAMPLE);

    assign in_ready  = w_en1;
    assign out_valid = r_s3_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s2_valid <= 1'b0;
            r_s3_valid <= 1'b0;
        end else begin
            if (w_en1) r_s1_valid <= in_valid;
            if (w_en2) r_s2_valid <= r_s1_valid;
            if (w_en3) r_s3_valid <= r_s2_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (w_ld1) r_s1_mode <= mode_e'(in_mode);
        if (w_ld2) r_s2_mode <= r_s1_mode;
    end

    for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
        plan_lane #(
            .SUM_W     (SUM_W),
            .FRAC_BITS (FRAC_BITS),
            .OUT_W     (OUT_W),
            .SEED      (SEED ^ 16'(k))
        ) u_lane (
            .clk      (clk),
            .rst      (rst),
            .i_ld1    (w_ld1),
            .i_ld2    (w_ld2),
            .i_ld3    (w_ld3),
            .i_sample (w_sample3),
            .i_sum    (in_sum[k*SUM_W +: SUM_W]),
            .o_prob   (out_prob[k*OUT_W +: OUT_W]),
            .o_state  (out_state[k])
        );
    end

endmodule

// File: tb/tb_sigmoid_sampler.sv
// Self-checking bench for sigmoid_sampler: vector table, scoreboard with an independent
// real-valued PLAN model and LFSR model, back-pressure, sampling statistics and reset cases.
module tb_sigmoid_sampler;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_sum;
    logic        in_mode;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_prob;
    logic [3:0]  out_state;

    sigmoid_sampler dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sum    (in_sum),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_prob  (out_prob),
        .out_state (out_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] prob;
        logic [3:0]  state;
    } exp_t;

    typedef struct {
        logic [63:0] sum;
        logic [31:0] prob;
    } vec_t;

    exp_t        sb[$];
    logic [15:0] m_lfsr[4];
    int          n_cmp = 0;
    int          n_bad = 0;

    // statistics collected by the monitor
    bit          cnt_en = 0;
    int          ones[4];
    int          sig = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        logic [15:0] n;
        n = {1'b0, s[15:1]};
        if (s[0]) n = n ^ 16'hB400;
        return n;
    endfunction

    function automatic logic [7:0] model_prob(input logic [15:0] x);
        int  mag;
        int  y;
        real ax;
        mag = x[15] ? (65536 - int'(x)) : int'(x);
        ax  = real'(mag) / 16.0;
        if (ax > 5.0)        y = 256;
        else if (ax > 2.375) y = $rtoi(ax / 32.0 * 256.0) + $rtoi(0.84375 * 256.0);
        else if (ax > 1.0)   y = $rtoi(ax / 8.0 * 256.0)  + $rtoi(0.625 * 256.0);
        else                 y = $rtoi(ax / 4.0 * 256.0)  + $rtoi(0.5 * 256.0);
        if (x[15]) y = 256 - y;
        return (y > 255) ? 8'hFF : y[7:0];
    endfunction

    function automatic exp_t model_beat(input logic [63:0] sum, input logic mode);
        exp_t       e;
        logic [7:0] p;
        for (int k = 0; k < 4; k++) begin
            p = model_prob(sum[k*16 +: 16]);
            e.prob[k*8 +: 8] = p;
            e.state[k] = mode && (m_lfsr[k][15:8] < p);
            if (mode) m_lfsr[k] = lfsr_step(m_lfsr[k]);
        end
        return e;
    endfunction

    function automatic void model_reset();
        for (int k = 0; k < 4; k++) m_lfsr[k] = 16'hACE1 ^ 16'(k);
        sb.delete();
    endfunction

    // Called at posedge+1; returns at posedge+1 after the beat is accepted.
    task automatic send(input logic [63:0] sum, input logic mode,
                        input bit use_tbl, input logic [31:0] tbl_prob);
        int   n;
        exp_t e;
        in_valid = 1'b1;
        in_sum   = sum;
        in_mode  = mode;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            n++;
            @(negedge clk);
        end
        if (!in_ready) begin
            n_cmp++;
            n_bad++;
            $display("FAIL send_timeout: in_ready stayed low, expected acceptance");
        end else if (use_tbl) begin
            e.prob  = tbl_prob;
            e.state = 4'b0;
            sb.push_back(e);
        end else begin
            sb.push_back(model_beat(sum, mode));
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb.size() != 0 || out_valid) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain_timeout: %0d beats outstanding, expected 0", sb.size());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic check_range(input string name, input int v, input int lo, input int hi);
        n_cmp++;
        if (v < lo || v > hi) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, v, lo, hi);
        end
    endtask

    // Output monitor: samples on the falling edge, pops the scoreboard on each handshake
    // and checks that a stalled output holds its value.
    bit          hold_flag = 0;
    logic [31:0] held_prob;
    logic [3:0]  held_state;

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            hold_flag = 0;
        end else begin
            if (hold_flag) begin
                check("hold_valid", out_valid, 1);
                check("hold_prob", out_prob, held_prob);
                check("hold_state", out_state, held_state);
            end
            hold_flag  = out_valid && !out_ready;
            held_prob  = out_prob;
            held_state = out_state;
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_beat: prob %0h with empty scoreboard", out_prob);
                end else begin
                    e = sb.pop_front();
                    check("prob", out_prob, e.prob);
                    check("state", out_state, e.state);
                    if (cnt_en) begin
                        for (int k = 0; k < 4; k++) ones[k] += int'(out_state[k]);
                        sig = sig * 33 + int'(out_state);
                    end
                end
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    vec_t tbl[5];
    int   lat;
    int   cnt;
    int   sig_run1;
    logic [15:0] xv;
    logic [15:0] pattern;

    initial begin
        tbl[0] = '{64'h0020_FFF0_0010_0000, 32'hE0_40_C0_80};   // 0, +1, -1, +2
        tbl[1] = '{64'h8000_FFA0_0060_0050, 32'h00_00_FF_FF};   // +5, +6, -6, min
        tbl[2] = '{64'h0011_FFDA_0027_0026, 32'hC2_14_EB_EC};   // 2.375 / 1.0 edges
        tbl[3] = '{64'hFFB0_7FFF_FFFF_004F, 32'h00_FF_7C_FF};   // 4.9375, -1/16, max, -5
        tbl[4] = '{64'hFFC0_0030_FFE0_0008, 32'h08_F0_20_A0};   // 0.5, -2, 3, -4

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_sum    = '0;
        in_mode   = 1'b0;
        out_ready = 1'b1;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_prob", out_prob, 0);
        check("rst_out_state", out_state, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        @(posedge clk);
        #1;

        // Table-driven PROB vectors with latency measured on each.
        for (int i = 0; i < 5; i++) begin
            send(tbl[i].sum, 1'b0, 1'b1, tbl[i].prob);
            lat = 0;
            do begin
                @(negedge clk);
                lat++;
            end while (!out_valid && lat < 10);
            check("latency", lat, 3);
            drain();
        end

        // Back-pressure: 10 streamed beats, out_ready low on cycles 4-8.
        fork
            for (int i = 0; i < 10; i++) begin
                logic [15:0] v;
                v = 16'(i * 7 - 30);
                send({v, ~v, v, 16'h0020}, 1'(i % 2), 1'b0, 32'h0);
            end
            begin
                repeat (4) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (3) @(posedge clk);
                @(negedge clk);
                check("stall_in_ready", in_ready, 0);
                check("stall_out_valid", out_valid, 1);
                repeat (2) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain();
        check("bp_no_leftover", sb.size(), 0);

        // SAMPLE at x=0: ones statistics and reproducibility after reset.
        for (int run = 0; run < 2; run++) begin
            reset_dut();
            for (int k = 0; k < 4; k++) ones[k] = 0;
            sig    = 0;
            cnt_en = 1;
            for (int i = 0; i < 4096; i++) send(64'h0, 1'b1, 1'b0, 32'h0);
            drain();
            cnt_en = 0;
            if (run == 0) begin
                sig_run1 = sig;
                for (int k = 0; k < 4; k++) check_range("ones_count", ones[k], 1920, 2176);
            end else begin
                check("rerun_signature", sig, sig_run1);
            end
        end

        // x = -6 in SAMPLE never fires.
        for (int i = 0; i < 64; i++) send({4{16'hFFA0}}, 1'b1, 1'b0, 32'h0);
        drain();

        // Interleaved PROB / SAMPLE beats, LFSR steps only on SAMPLE.
        pattern = 16'b0110_1001_1100_0101;
        for (int i = 0; i < 16; i++) begin
            xv = 16'($urandom_range(0, 255)) - 16'd128;
            send({xv, 16'h0000, ~xv, xv}, pattern[i], 1'b0, 32'h0);
        end
        drain();

        // Reset with two beats in flight.
        send(64'h0, 1'b1, 1'b0, 32'h0);
        send(64'h0010_0010_0010_0010, 1'b1, 1'b0, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("midrst_out_valid", out_valid, 0);
        cnt = 0;
        repeat (6) begin
            @(negedge clk);
            if (out_valid) cnt++;
        end
        check("midrst_no_stale", cnt, 0);
        @(posedge clk);
        #1;
        for (int i = 0; i < 12; i++) send(64'h0, 1'b1, 1'b0, 32'h0);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
